// File: rtl/data_memory_pkg.sv
// Shared definitions for the two-port data memory arbiter: state encoding,
// access-type encoding and default bus widths.
package data_memory_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  // Encoding of the sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Encoding of the memory read_write strobe.
  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/data_memory_arbiter_checker.sv
// Run-time invariants of the arbiter outputs; not part of the datapath.
module data_memory_arbiter_checker
  import data_memory_pkg::*;
(
  input logic       clk,
  input logic       rst_n,
  input logic [1:0] state,
  input logic       ack0,
  input logic       ack1,
  input logic       mem_read_write
);

  // Both ports must never be acknowledged in the same cycle.
  ack_exclusive_a : assert property (@(posedge clk) disable iff (!rst_n)
    !(ack0 && ack1));

  // The write strobe may only be raised while the memory access is in flight.
  write_only_in_access_a : assert property (@(posedge clk) disable iff (!rst_n)
    mem_read_write |-> (state == 2'(ST_ACCESS)));

endmodule

// File: rtl/data_memory_arbiter_rr_arbiter2.sv
// Combinational 2-way round-robin pick. A lone requester always wins; on a
// tie the port that did not win last time is chosen.
module rr_arbiter2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  // Select the winning port from the request pair and the previous winner.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    case ({req1, req0})
      2'b01: begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end
      2'b10: begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
      2'b11: begin
        grant_valid = 1'b1;
        grant_id    = ~last_grant;
      end
      default: begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of a single-port
// data memory. Port 0 is the CPU data path, port 1 the debug/loader port.
// Each access takes IDLE -> ACCESS -> DONE; the ack pulse and the read data
// are registered, and the memory sees stable address/data/rw for the whole
// ACCESS cycle.
module data_memory_arbiter
  import data_memory_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read_write,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  state_e              state_r;
  logic                grant_r;
  logic                last_grant_r;
  logic                ack0_r;
  logic                ack1_r;
  logic [DATA_W-1:0]   rdata0_r;
  logic [DATA_W-1:0]   rdata1_r;
  logic [ADDR_W-1:0]   mem_address_r;
  logic [DATA_W-1:0]   mem_wdata_r;
  logic                mem_rw_r;
  logic                busy_r;

  logic                grant_valid_s;
  logic                grant_id_s;
  logic                sel_we_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_wdata_s;

  rr_arbiter2 u_rr_arbiter2 (
    .req0        (req0),
    .req1        (req1),
    .last_grant  (last_grant_r),
    .grant_valid (grant_valid_s),
    .grant_id    (grant_id_s)
  );

  // Route the winning port's request fields toward the memory registers.
  always_comb begin
    sel_we_s    = RW_READ;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    if (grant_id_s) begin
      sel_we_s    = we1;
      sel_addr_s  = addr1;
      sel_wdata_s = wdata1;
    end else begin
      sel_we_s    = we0;
      sel_addr_s  = addr0;
      sel_wdata_s = wdata0;
    end
  end

  // Sequencer: latch a winner in IDLE, run one memory cycle, pulse ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      grant_r       <= 1'b0;
      last_grant_r  <= 1'b1;
      ack0_r        <= 1'b0;
      ack1_r        <= 1'b0;
      rdata0_r      <= '0;
      rdata1_r      <= '0;
      mem_address_r <= '0;
      mem_wdata_r   <= '0;
      mem_rw_r      <= RW_READ;
      busy_r        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ack0_r <= 1'b0;
          ack1_r <= 1'b0;
          if (grant_valid_s) begin
            grant_r       <= grant_id_s;
            last_grant_r  <= grant_id_s;
            mem_address_r <= sel_addr_s;
            mem_wdata_r   <= sel_wdata_s;
            mem_rw_r      <= sel_we_s;
            busy_r        <= 1'b1;
            state_r       <= ST_ACCESS;
          end else begin
            mem_rw_r <= RW_READ;
            busy_r   <= 1'b0;
          end
        end
        ST_ACCESS: begin
          // A write commits at this edge; a read captures the memory output.
          if (mem_rw_r == RW_READ) begin
            if (grant_r) begin
              rdata1_r <= mem_read_data;
            end else begin
              rdata0_r <= mem_read_data;
            end
          end
          mem_rw_r <= RW_READ;
          ack0_r   <= ~grant_r;
          ack1_r   <= grant_r;
          state_r  <= ST_DONE;
        end
        ST_DONE: begin
          ack0_r  <= 1'b0;
          ack1_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          ack0_r   <= 1'b0;
          ack1_r   <= 1'b0;
          mem_rw_r <= RW_READ;
          busy_r   <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack0           = ack0_r;
  assign ack1           = ack1_r;
  assign rdata0         = rdata0_r;
  assign rdata1         = rdata1_r;
  assign mem_address    = mem_address_r;
  assign mem_write_data = mem_wdata_r;
  assign busy           = busy_r;
  // The strobe register only clears at the reset edge itself, which is also
  // the edge that would commit a write; qualifying with rst_n keeps an
  // aborted ACCESS write from reaching the memory.
  assign mem_read_write = mem_rw_r & rst_n;

  data_memory_arbiter_checker u_checker (
    .clk            (clk),
    .rst_n          (rst_n),
    .state          (state_r),
    .ack0           (ack0),
    .ack1           (ack1),
    .mem_read_write (mem_read_write)
  );

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench for data_memory_arbiter with a behavioural 256x8 memory.
module tb_data_memory_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, we0, req1, we1;
  logic [7:0] addr0, wdata0, addr1, wdata1;
  logic       ack0, ack1;
  logic [7:0] rdata0, rdata1;
  logic [7:0] mem_address, mem_write_data, mem_read_data;
  logic       mem_read_write;
  logic       busy;

  always #5 clk = ~clk;

  data_memory_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_write(mem_read_write), .mem_read_data(mem_read_data), .busy(busy)
  );

  // Behavioural memory: combinational read, write at posedge.
  logic [7:0] mem [0:255];
  assign mem_read_data = mem[mem_address];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[101] = 8'h11;
    mem[102] = 8'h22;
    mem[104] = 8'h44;
    mem[105] = 8'h55;
    forever begin
      @(posedge clk);
      if (mem_read_write) mem[mem_address] <= mem_write_data;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       port;
    logic       rd;
    logic [7:0] data;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] ref_mem [0:255];
  int         ack_port_q[$];
  int         ack_cyc_q[$];
  int         rw_cnt = 0;
  int         busy_cnt = 0;
  int         total_cnt = 0;
  int         bad_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor: pop the scoreboard on every ack and check port and read data.
  initial begin
    logic [7:0] exp_rd0;
    logic [7:0] exp_rd1;
    exp_t       e;
    exp_rd0 = 8'h00;
    exp_rd1 = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_rd0 = 8'h00;
        exp_rd1 = 8'h00;
      end else begin
        if (mem_read_write) rw_cnt++;
        if (busy) busy_cnt++;
        if (ack0 || ack1) begin
          check_val("ack_exclusive", {31'd0, ack0 & ack1}, 32'd0);
          if (sb_q.size() == 0) begin
            check_val("unexpected_ack", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            check_val("ack_port", {31'd0, ack1}, {31'd0, e.port});
            if (e.rd) begin
              if (e.port) exp_rd1 = e.data;
              else        exp_rd0 = e.data;
            end
            check_val("rdata0", {24'd0, rdata0}, {24'd0, exp_rd0});
            check_val("rdata1", {24'd0, rdata1}, {24'd0, exp_rd1});
          end
          ack_port_q.push_back(ack1 ? 1 : 0);
          ack_cyc_q.push_back(cyc);
        end
      end
    end
  end

  task automatic push_exp(input logic port, input logic we, input logic [7:0] addr,
                          input logic [7:0] wd);
    exp_t e;
    e.port = port;
    e.rd   = ~we;
    e.data = we ? 8'h00 : ref_mem[addr];
    sb_q.push_back(e);
    if (we) ref_mem[addr] = wd;
  endtask

  task automatic wait_ack(input logic port, output int at);
    at = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (port ? ack1 : ack0) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check_val("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic drive_port(input logic port, input logic we, input logic [7:0] addr,
                            input logic [7:0] wd);
    if (port) begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd;
    end
  endtask

  task automatic do_access(input logic port, input logic we, input logic [7:0] addr,
                           input logic [7:0] wd);
    int start;
    int at;
    @(posedge clk); #1;
    drive_port(port, we, addr, wd);
    push_exp(port, we, addr, wd);
    start = cyc;
    wait_ack(port, at);
    if (at >= 0) check_val("latency", at - start, 32'd2);
    @(posedge clk); #1;
    if (port) req1 = 1'b0;
    else      req0 = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_ack0"}, {31'd0, ack0}, 32'd0);
    check_val({tag, "_ack1"}, {31'd0, ack1}, 32'd0);
    check_val({tag, "_rdata0"}, {24'd0, rdata0}, 32'd0);
    check_val({tag, "_rdata1"}, {24'd0, rdata1}, 32'd0);
    check_val({tag, "_mem_address"}, {24'd0, mem_address}, 32'd0);
    check_val({tag, "_mem_write_data"}, {24'd0, mem_write_data}, 32'd0);
    check_val({tag, "_mem_read_write"}, {31'd0, mem_read_write}, 32'd0);
    check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int a0, a1, base, rw_base, busy_base, n_acks;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    ref_mem[101] = 8'h11;
    ref_mem[102] = 8'h22;
    ref_mem[104] = 8'h44;
    ref_mem[105] = 8'h55;
    rst_n = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = 8'd0; wdata0 = 8'd0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 8'd0; wdata1 = 8'd0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Port 0 write then read of address 100.
    do_access(1'b0, 1'b1, 8'd100, 8'h5A);
    do_access(1'b0, 1'b0, 8'd100, 8'h00);

    // Simultaneous requests straight after reset: port 0 first.
    apply_reset();
    @(posedge clk); #1;
    drive_port(1'b0, 1'b0, 8'd101, 8'h00);
    drive_port(1'b1, 1'b0, 8'd102, 8'h00);
    push_exp(1'b0, 1'b0, 8'd101, 8'h00);
    push_exp(1'b1, 1'b0, 8'd102, 8'h00);
    wait_ack(1'b0, a0);
    @(posedge clk); #1 req0 = 1'b0;
    wait_ack(1'b1, a1);
    if (a0 >= 0 && a1 >= 0) check_val("tie_gap", a1 - a0, 32'd3);
    @(posedge clk); #1 req1 = 1'b0;

    // Both ports requesting continuously for six accesses.
    base = ack_port_q.size();
    @(posedge clk); #1;
    drive_port(1'b0, 1'b0, 8'd101, 8'h00);
    drive_port(1'b1, 1'b0, 8'd102, 8'h00);
    for (int i = 0; i < 3; i++) begin
      push_exp(1'b0, 1'b0, 8'd101, 8'h00);
      push_exp(1'b1, 1'b0, 8'd102, 8'h00);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack_port_q.size() >= base + 6) break;
    end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    n_acks = ack_port_q.size() - base;
    check_val("rr_ack_count", n_acks, 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < n_acks) check_val("rr_alternate", ack_port_q[base + i], i % 2);
      if (i > 0 && i < n_acks)
        check_val("rr_gap", ack_cyc_q[base + i] - ack_cyc_q[base + i - 1], 32'd3);
    end

    // Port 1 write to the top address with port 0 idle.
    rw_base   = rw_cnt;
    busy_base = busy_cnt;
    do_access(1'b1, 1'b1, 8'hFF, 8'hFF);
    repeat (3) @(negedge clk);
    check_val("wr255_rw_cycles", rw_cnt - rw_base, 32'd1);
    check_val("wr255_busy_cycles", busy_cnt - busy_base, 32'd2);
    check_val("wr255_mem", {24'd0, mem[255]}, 32'h0000_00FF);

    // Reset during ACCESS of a write: write suppressed, no ack, outputs cleared.
    @(posedge clk); #1;
    drive_port(1'b0, 1'b1, 8'd103, 8'hAA);
    @(posedge clk); #1;
    check_val("abort_rw_in_access", {31'd0, mem_read_write}, 32'd1);
    rst_n = 1'b0;
    req0  = 1'b0;
    base  = ack_port_q.size();
    @(posedge clk);
    @(negedge clk);
    check_outputs_zero("abort");
    check_val("abort_mem103", {24'd0, mem[103]}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_val("abort_no_ack", ack_port_q.size() - base, 32'd0);

    // Address changed during ACCESS of a read: latched address is used.
    @(posedge clk); #1;
    drive_port(1'b0, 1'b0, 8'd104, 8'h00);
    push_exp(1'b0, 1'b0, 8'd104, 8'h00);
    @(posedge clk); #1 addr0 = 8'd105;
    @(negedge clk);
    check_val("isolate_mem_address", {24'd0, mem_address}, 32'd104);
    wait_ack(1'b0, a0);
    @(posedge clk); #1 req0 = 1'b0;

    repeat (3) @(negedge clk);
    check_val("scoreboard_drained", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
